// File: rtl/rr_en_arbiter_if.sv
// Request/grant bundle between the requesters (master) and the round-robin
// enable arbiter (slave). The arbiter registers every output.
interface rr_en_arbiter_if #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
);
    logic [N-1:0] req;
    logic         stall;
    logic [N-1:0] gnt;
    logic         en;
    logic [W-1:0] ptr;
    logic [N-1:0] starve;

    modport master (
        output req, stall,
        input  gnt, en, ptr, starve
    );

    modport slave (
        input  req, stall,
        output gnt, en, ptr, starve
    );
endinterface

// File: rtl/rr_en_arbiter.sv
// Round-robin arbiter producing one registered one-hot grant per cycle and the
// downstream enable (en = |gnt), with a sticky per-requester starvation monitor.
//
// Handshake: req is a level request with no acknowledge. A grant at edge k uses
// only the req/stall values sampled at edge k; stall wins over any request.
module rr_en_arbiter #(
    parameter int N          = 4,
    parameter int STARVE_LIM = 8
) (
    input logic            clk,
    input logic            rst,
    rr_en_arbiter_if.slave bus
);
    localparam int W  = (N > 1) ? $clog2(N) : 1;
    localparam int CW = $clog2(STARVE_LIM + 1);
    localparam logic [CW-1:0] LIM = CW'(STARVE_LIM);

    logic [N-1:0]  gnt_q;
    logic          en_q;
    logic [W-1:0]  ptr_q;
    logic [N-1:0]  starve_q;
    logic [CW-1:0] wait_q    [N];

    logic [W-1:0]  scan;
    logic [W-1:0]  pick;
    logic          found;
    logic [N-1:0]  gnt_next;
    logic [W-1:0]  ptr_next;
    logic [CW-1:0] wait_next [N];

    // First set request at or after the pointer, wrapping modulo N.
    always_comb begin
        scan  = '0;
        pick  = '0;
        found = 1'b0;
        for (int k = 0; k < N; k++) begin
            scan = W'((int'(ptr_q) + k) % N);
            if (!found && bus.req[scan]) begin
                found = 1'b1;
                pick  = scan;
            end
        end
    end

    always_comb begin
        gnt_next = '0;
        ptr_next = ptr_q;
        if (!bus.stall && found) begin
            gnt_next[pick] = 1'b1;
            ptr_next       = W'((int'(pick) + 1) % N);
        end
    end

    // A waiting requester counts every cycle it is passed over, stalls included.
    always_comb begin
        for (int i = 0; i < N; i++) begin
            wait_next[i] = '0;
            if (bus.req[i] && !gnt_next[i]) begin
                wait_next[i] = (wait_q[i] == LIM) ? LIM : wait_q[i] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            gnt_q    <= '0;
            en_q     <= 1'b0;
            ptr_q    <= '0;
            starve_q <= '0;
            for (int i = 0; i < N; i++) begin
                wait_q[i] <= '0;
            end
        end else begin
            gnt_q <= gnt_next;
            en_q  <= |gnt_next;
            ptr_q <= ptr_next;
            for (int i = 0; i < N; i++) begin
                wait_q[i] <= wait_next[i];
                if (wait_next[i] == LIM) begin
                    starve_q[i] <= 1'b1;
                end
            end
        end
    end

    assign bus.gnt    = gnt_q;
    assign bus.en     = en_q;
    assign bus.ptr    = ptr_q;
    assign bus.starve = starve_q;
endmodule

// File: tb/tb_rr_en_arbiter.sv
// Bench for rr_en_arbiter: directed vectors with literal expectations plus a
// per-cycle comparison against a behavioural round-robin model.
module tb_rr_en_arbiter;
  localparam int N   = 4;
  localparam int LIM = 8;
  localparam int W   = 2;
  localparam int OW  = 2 * N + W + 1;

  logic clk = 1'b0;
  logic rst = 1'b0;

  rr_en_arbiter_if #(.N(N)) bus ();

  rr_en_arbiter #(.N(N), .STARVE_LIM(LIM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checking helpers ----------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int           m_ptr;
  int           m_wait [N];
  logic [N-1:0] m_gnt;
  logic [N-1:0] m_starve;
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] cur_exp;

  task automatic model_reset();
    m_ptr    = 0;
    m_gnt    = '0;
    m_starve = '0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endtask

  task automatic model_step(input logic [N-1:0] r, input logic s);
    int g;
    int idx;
    g = -1;
    if (!s) begin
      for (int k = 0; k < N; k++) begin
        idx = (m_ptr + k) % N;
        if (g < 0 && r[idx[W-1:0]]) g = idx;
      end
    end
    m_gnt = '0;
    if (g >= 0) begin
      m_gnt[g[W-1:0]] = 1'b1;
      m_ptr = (g + 1) % N;
    end
    for (int i = 0; i < N; i++) begin
      if (r[i[W-1:0]] && g != i) m_wait[i] = (m_wait[i] + 1 > LIM) ? LIM : m_wait[i] + 1;
      else m_wait[i] = 0;
      if (m_wait[i] >= LIM) m_starve[i[W-1:0]] = 1'b1;
    end
  endtask

  always @(negedge rst) model_reset();

  // One compare per clock edge, 1 time unit after the edge.
  always @(posedge clk) begin
    if (!rst) model_reset();
    else model_step(bus.req, bus.stall);
    exp_q.push_back({m_starve, W'(m_ptr), |m_gnt, m_gnt});
    #1;
    if (exp_q.size() == 0) begin
      check("model_queue_empty", 32'd0, 32'd1);
    end else begin
      cur_exp = exp_q.pop_front();
      check("model_gnt",    32'(bus.gnt),    32'(cur_exp[N-1:0]));
      check("model_en",     32'(bus.en),     32'(cur_exp[N]));
      check("model_ptr",    32'(bus.ptr),    32'(cur_exp[N+W:N+1]));
      check("model_starve", 32'(bus.starve), 32'(cur_exp[OW-1:N+W+1]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input logic [N-1:0] r, input logic s);
    @(negedge clk);
    bus.req   = r;
    bus.stall = s;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [N-1:0] g, input logic [W-1:0] p);
    check({name, "_gnt"}, 32'(bus.gnt), 32'(g));
    check({name, "_en"},  32'(bus.en),  32'(g != '0));
    check({name, "_ptr"}, 32'(bus.ptr), 32'(p));
  endtask

  typedef struct packed {
    logic [N-1:0] r;
    logic         s;
  } vec_t;

  vec_t mix [10];

  // ---------------- directed stimulus ----------------
  initial begin
    bus.req   = '0;
    bus.stall = 1'b0;
    #12;
    check("reset_gnt",    32'(bus.gnt),    32'd0);
    check("reset_en",     32'(bus.en),     32'd0);
    check("reset_ptr",    32'(bus.ptr),    32'd0);
    check("reset_starve", 32'(bus.starve), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // full rotation with every requester active
    cyc(4'b1111, 1'b0); lit("t2_a", 4'b0001, 2'd1);
    cyc(4'b1111, 1'b0); lit("t2_b", 4'b0010, 2'd2);
    cyc(4'b1111, 1'b0); lit("t2_c", 4'b0100, 2'd3);
    cyc(4'b1111, 1'b0); lit("t2_d", 4'b1000, 2'd0);
    cyc(4'b1111, 1'b0); lit("t2_e", 4'b0001, 2'd1);

    // wrap from ptr=3 back to the low requesters
    cyc(4'b1111, 1'b0); lit("t3_a", 4'b0010, 2'd2);
    cyc(4'b1111, 1'b0); lit("t3_b", 4'b0100, 2'd3);
    cyc(4'b0011, 1'b0); lit("t3_c", 4'b0001, 2'd1);
    cyc(4'b0011, 1'b0); lit("t3_d", 4'b0010, 2'd2);

    // async reset between edges while gnt=0100, ptr=3
    cyc(4'b0100, 1'b0); lit("t1_pre", 4'b0100, 2'd3);
    rst = 1'b0;
    #1;
    check("t1_gnt",    32'(bus.gnt),    32'd0);
    check("t1_en",     32'(bus.en),     32'd0);
    check("t1_ptr",    32'(bus.ptr),    32'd0);
    check("t1_starve", 32'(bus.starve), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // lone requester granted every cycle, drops one cycle after req falls
    for (int k = 0; k < 5; k++) begin
      cyc(4'b0010, 1'b0); lit("t4_hold", 4'b0010, 2'd2);
    end
    cyc(4'b0000, 1'b0); lit("t4_drop", 4'b0000, 2'd2);

    // prolonged stall: starve sets exactly on the 8th stalled edge
    for (int k = 0; k < LIM; k++) begin
      cyc(4'b1111, 1'b1); lit("t5_stall", 4'b0000, 2'd2);
      if (k == LIM - 2) check("t5_starve_7th", 32'(bus.starve), 32'h0);
    end
    check("t5_starve_8th", 32'(bus.starve), 32'hf);
    cyc(4'b1111, 1'b0); lit("t5_resume_a", 4'b0100, 2'd3);
    cyc(4'b1111, 1'b0); lit("t5_resume_b", 4'b1000, 2'd0);
    cyc(4'b1111, 1'b0); lit("t5_resume_c", 4'b0001, 2'd1);
    check("t5_starve_sticky", 32'(bus.starve), 32'hf);

    // mixed patterns covered by the per-cycle model compare
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    mix[0] = '{r: 4'b0101, s: 1'b0};
    mix[1] = '{r: 4'b0101, s: 1'b1};
    mix[2] = '{r: 4'b1010, s: 1'b0};
    mix[3] = '{r: 4'b0110, s: 1'b0};
    mix[4] = '{r: 4'b0000, s: 1'b0};
    mix[5] = '{r: 4'b1001, s: 1'b0};
    mix[6] = '{r: 4'b1001, s: 1'b0};
    mix[7] = '{r: 4'b1111, s: 1'b1};
    mix[8] = '{r: 4'b1000, s: 1'b0};
    mix[9] = '{r: 4'b0001, s: 1'b0};
    for (int k = 0; k < 10; k++) cyc(mix[k].r, mix[k].s);
    lit("mix_last", 4'b0001, 2'd1);

    cyc(4'b0000, 1'b0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
